mem_stage_dm: RTL and testbench
===============================

Name: mem_stage_dm

Overview:
- MEM-stage data memory and result-select block. Sits between the EX/MEM pipeline register and MEM_WB.
- Holds the word-addressed data RAM and performs byte, halfword and word stores with byte enables.
- Performs sign- and zero-extended loads.
- Muxes the final write-back value MEM_WD that MEM_WB captures on the same edge.

Parameters:
- DM_WORDS, 3072, number of 32-bit words in the data RAM.
- ADDR_W, 12, word-index width (covers DM_WORDS); byte address bits [ADDR_W+1:2] index the RAM.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears RAM.
- MEM_PC  in  32  PC of the instruction in MEM.
- MEM_ALUout  in  32  byte address for loads/stores, or the ALU result.
- MEM_RTdata  in  32  store data, already forwarded.
- MEM_MDout  in  32  HI/LO value carried from EX (mfhi/mflo).
- MEM_MemWrite  in  1  store enable.
- MEM_MemOp  in  3  access size/extension: 0 word, 1 half zero-ext, 2 half sign-ext, 3 byte zero-ext, 4 byte sign-ext; 5-7 reserved, treated as word.
- MEM_WDSel  in  2  write-back select: 0 ALUout, 1 load data, 2 MEM_PC+8, 3 MDout.
- MEM_RD  out  32  extended load data (combinational).
- MEM_WD  out  32  selected write-back value (combinational) to MEM_WB.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: on a posedge with reset=1, every RAM word becomes 0 and any store in that cycle is dropped.
  - Outputs are combinational. After reset they reflect the zeroed RAM, so a load reads 0.
- Address decode:
  - idx = MEM_ALUout[ADDR_W+1:2].
  - Out of range (idx >= DM_WORDS, or any MEM_ALUout bit above ADDR_W+1 set): reads return raw word 0; writes are ignored with no RAM change.
- Read: asynchronous, zero-cycle latency. raw = RAM[idx].
  - Halfword select by addr[1]: 0 picks raw[15:0], 1 picks raw[31:16]. addr[0] is ignored.
  - Byte select by addr[1:0]: lane 0 is raw[7:0] ... lane 3 is raw[31:24].
  - Extension per MemOp gives MEM_RD.
- Write: at the posedge when MEM_MemWrite=1 and reset=0.
  - Word: all 4 byte enables set, data = RTdata. addr[1:0] ignored; access is force-aligned.
  - Half: lanes {1,0} or {3,2} by addr[1]. Data = RTdata[15:0] replicated into the selected half.
  - Byte: one lane by addr[1:0]. Data = RTdata[7:0] in that lane.
  - Unselected bytes keep their old value.
- Read-during-write at the same address in the same cycle: MEM_RD shows the old contents. The new contents are visible from the next cycle.
- MEM_WD mux:
  - WDSel 0 gives MEM_ALUout; 1 gives MEM_RD; 2 gives MEM_PC+32'd8 (mod 2^32 wrap); 3 gives MEM_MDout.
  - No X propagation: all 2-bit codes are defined.
- No stall or flush inputs. A bubble arrives as MemWrite=0 and causes no state change.
- Reset asserted mid-stream: the RAM clear takes priority over the concurrent store; the next cycle proceeds normally.

Optional Feature:
- Macro DM_WRITE_TRACE_EN.
- Defined: on every committed store (not dropped by reset, address in range), emit $display("%d@%h: *%h <= %h", $time, MEM_PC, {MEM_ALUout[31:2],2'b00}, merged_word), where merged_word is the full 32-bit word after the byte-enable merge.
- Undefined: no display code is compiled; functional behaviour is identical.

Test Plan:
- Reset clears RAM: write sw 0x12345678 to addr 0x10, assert reset for one edge, then lw 0x10 -> MEM_RD=0x00000000.
- Byte store/load: RAM[0x20]=0x00000000; sb RTdata=0x000000AB at 0x22 -> word 0x00AB0000. lb 0x22 gives 0xFFFFFFAB; lbu 0x22 gives 0x000000AB.
- Halfword store/load: sh RTdata=0x0000BEEF at 0x32 over 0x11223344 -> word 0xBEEF3344. lh 0x32 gives 0xFFFFBEEF; lhu 0x30 gives 0x00003344.
- Read-during-write: RAM[0x40]=0xAAAAAAAA; sw 0x55555555 at 0x40 with WDSel=1 in the same cycle -> MEM_WD=0xAAAAAAAA that cycle; next-cycle lw gives 0x55555555.
- WD mux: ALUout=0x7, MEM_PC=0x00003000, MDout=0x9. WDSel 0/1/2/3 -> 0x7 / RAM data / 0x00003008 / 0x9. MEM_PC=0xFFFFFFFC with WDSel=2 -> 0x00000004.
- Out of range: sw 0xDEADBEEF to addr 0x00003000 (idx 3072) -> no RAM word changes, lw at the same address gives 0, and no trace is printed when DM_WRITE_TRACE_EN is defined.

Source files
------------

// File: rtl/mem_stage_dm.sv
// MEM-stage data RAM with byte/half/word stores and extended loads, plus write-back select.
// Latency: reads and MEM_WD are combinational; stores commit on the next posedge.
// Backpressure: none, every cycle is accepted; a bubble is MemWrite=0. Optional macro: DM_WRITE_TRACE_EN.
module mem_stage_dm #(
  parameter int DM_WORDS = 3072,
  parameter int ADDR_W   = 12     // must stay below 30 so the upper-bit range check has bits to test
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] MEM_PC,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_RTdata,
  input  logic [31:0] MEM_MDout,
  input  logic        MEM_MemWrite,
  input  logic [2:0]  MEM_MemOp,
  input  logic [1:0]  MEM_WDSel,
  output logic [31:0] MEM_RD,
  output logic [31:0] MEM_WD
);

  logic [31:0]       mem [DM_WORDS];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic [31:0]       raw;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       merged;

  assign idx = MEM_ALUout[ADDR_W+1:2];
  // Bits above the word index must be clear, and the index itself may exceed the RAM depth.
  assign in_range = (MEM_ALUout[31:ADDR_W+2] == '0) && (32'(idx) < 32'(DM_WORDS));

  // Asynchronous read: pick the raw word, then the half/byte lane, then extend.
  always_comb begin
    raw      = in_range ? mem[idx] : 32'd0;
    half_sel = MEM_ALUout[1] ? raw[31:16] : raw[15:0];
    case (MEM_ALUout[1:0])
      2'd0:    byte_sel = raw[7:0];
      2'd1:    byte_sel = raw[15:8];
      2'd2:    byte_sel = raw[23:16];
      default: byte_sel = raw[31:24];
    endcase
    case (MEM_MemOp)
      3'd1:    MEM_RD = {16'd0, half_sel};
      3'd2:    MEM_RD = {{16{half_sel[15]}}, half_sel};
      3'd3:    MEM_RD = {24'd0, byte_sel};
      3'd4:    MEM_RD = {{24{byte_sel[7]}}, byte_sel};
      default: MEM_RD = raw;  // word, and reserved codes 5-7
    endcase
  end

  // Store lane enables and replicated data, merged over the current word so the RAM writes whole words.
  always_comb begin
    be    = 4'b1111;
    wdata = MEM_RTdata;
    case (MEM_MemOp)
      3'd1, 3'd2: begin
        be    = MEM_ALUout[1] ? 4'b1100 : 4'b0011;
        wdata = {2{MEM_RTdata[15:0]}};
      end
      3'd3, 3'd4: begin
        be    = 4'b0001 << MEM_ALUout[1:0];
        wdata = {4{MEM_RTdata[7:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = MEM_RTdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : raw[8*i +: 8];
    end
  end

  // RAM update: reset clears every word and wins over a concurrent store.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (MEM_MemWrite && in_range) begin
      mem[idx] <= merged;
`ifdef DM_WRITE_TRACE_EN
      $display("%d@%h: *%h <= %h", $time, MEM_PC, {MEM_ALUout[31:2], 2'b00}, merged);
`endif
    end
  end

  // Write-back select; every 2-bit code is defined.
  always_comb begin
    case (MEM_WDSel)
      2'd0:    MEM_WD = MEM_ALUout;
      2'd1:    MEM_WD = MEM_RD;
      2'd2:    MEM_WD = MEM_PC + 32'd8;
      default: MEM_WD = MEM_MDout;
    endcase
  end

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: directed vector table, then random traffic against a word-array model.
// Inputs change on the falling edge; outputs are sampled 1ns later, before the rising edge commits.
// The model is updated right after each rising edge.
module tb_mem_stage_dm;

  localparam int DEPTH = 3072;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] MEM_PC, MEM_ALUout, MEM_RTdata, MEM_MDout;
  logic        MEM_MemWrite;
  logic [2:0]  MEM_MemOp;
  logic [1:0]  MEM_WDSel;
  logic [31:0] MEM_RD, MEM_WD;

  mem_stage_dm #(.DM_WORDS(DEPTH), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset), .MEM_PC(MEM_PC), .MEM_ALUout(MEM_ALUout),
    .MEM_RTdata(MEM_RTdata), .MEM_MDout(MEM_MDout), .MEM_MemWrite(MEM_MemWrite),
    .MEM_MemOp(MEM_MemOp), .MEM_WDSel(MEM_WDSel), .MEM_RD(MEM_RD), .MEM_WD(MEM_WD)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic        we;
    logic [2:0]  op;
    logic [1:0]  sel;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [31:0] pc;
    logic [31:0] md;
    logic [31:0] erd;
    logic [31:0] ewd;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] m [DEPTH];
  int          compared = 0;
  int          mismatched = 0;

  function automatic vec_t mk(string nm, logic rst, logic we, logic [2:0] op, logic [1:0] sel,
                              logic [31:0] alu, logic [31:0] rt, logic [31:0] pc, logic [31:0] md,
                              logic [31:0] erd, logic [31:0] ewd);
    vec_t v;
    v.nm = nm; v.rst = rst; v.we = we; v.op = op; v.sel = sel; v.alu = alu;
    v.rt = rt; v.pc = pc; v.md = md; v.erd = erd; v.ewd = ewd;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    MEM_MemWrite = v.we;
    MEM_MemOp    = v.op;
    MEM_WDSel    = v.sel;
    MEM_ALUout   = v.alu;
    MEM_RTdata   = v.rt;
    MEM_PC       = v.pc;
    MEM_MDout    = v.md;
  endtask

  // Reference load: byte address below the RAM size hits the array, anything else reads 0.
  function automatic logic [31:0] mread(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] w, v;
    int sh;
    w = (a < LIMIT) ? m[a / 4] : 32'd0;
    case (op)
      3'd1, 3'd2: begin
        sh = ((a % 4) / 2) * 16;
        v  = (w >> sh) & 32'hFFFF;
        if (op == 3'd2 && v >= 32'h8000) v = v - 32'h10000;
      end
      3'd3, 3'd4: begin
        sh = (a % 4) * 8;
        v  = (w >> sh) & 32'hFF;
        if (op == 3'd4 && v >= 32'h80) v = v - 32'h100;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] mwd(input vec_t v, input logic [31:0] rd);
    case (v.sel)
      2'd0:    return v.alu;
      2'd1:    return rd;
      2'd2:    return v.pc + 32'd8;
      default: return v.md;
    endcase
  endfunction

  task automatic commit(input vec_t v);
    int nb, off;
    logic [63:0] mask64;
    logic [31:0] mask, data;
    if (v.rst) begin
      for (int i = 0; i < DEPTH; i++) m[i] = 32'd0;
    end else if (v.we && v.alu < LIMIT) begin
      nb  = (v.op == 3'd1 || v.op == 3'd2) ? 2 : (v.op == 3'd3 || v.op == 3'd4) ? 1 : 4;
      off = (nb == 2) ? int'(v.alu % 4) / 2 * 2 : (nb == 1) ? int'(v.alu % 4) : 0;
      mask64 = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
      mask   = mask64[31:0];
      data   = v.rt << (8 * off);
      m[v.alu / 4] = (m[v.alu / 4] & ~mask) | (data & mask);
    end
  endtask

  initial begin
    vec_t v;
    logic [31:0] erd;
    int r;

    reset = 1'b1; MEM_MemWrite = 1'b0; MEM_MemOp = 3'd0; MEM_WDSel = 2'd0;
    MEM_ALUout = 32'd0; MEM_RTdata = 32'd0; MEM_PC = 32'd0; MEM_MDout = 32'd0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < DEPTH; i++) m[i] = 32'd0;

    //                 name       rst we op sel alu          rt            pc            md     exp_rd        exp_wd
    tbl.push_back(mk("rst_lw10",  0, 0, 0, 1, 32'h10,   32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("sw10",      0, 1, 0, 0, 32'h10,   32'h12345678, 32'h0,        32'h0, 32'h0,        32'h10));
    tbl.push_back(mk("lw10",      0, 0, 0, 1, 32'h10,   32'h0,        32'h0,        32'h0, 32'h12345678, 32'h12345678));
    tbl.push_back(mk("rst_sw",    1, 1, 0, 0, 32'h10,   32'hFFFFFFFF, 32'h0,        32'h0, 32'h12345678, 32'h10));
    tbl.push_back(mk("lw10_clr",  0, 0, 0, 1, 32'h10,   32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("lw20",      0, 0, 0, 1, 32'h20,   32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("sb22",      0, 1, 3, 0, 32'h22,   32'hAB,       32'h0,        32'h0, 32'h0,        32'h22));
    tbl.push_back(mk("lw20_sb",   0, 0, 0, 1, 32'h20,   32'h0,        32'h0,        32'h0, 32'h00AB0000, 32'h00AB0000));
    tbl.push_back(mk("lb22",      0, 0, 4, 1, 32'h22,   32'h0,        32'h0,        32'h0, 32'hFFFFFFAB, 32'hFFFFFFAB));
    tbl.push_back(mk("lbu22",     0, 0, 3, 1, 32'h22,   32'h0,        32'h0,        32'h0, 32'h000000AB, 32'h000000AB));
    tbl.push_back(mk("sw30",      0, 1, 0, 0, 32'h30,   32'h11223344, 32'h0,        32'h0, 32'h0,        32'h30));
    tbl.push_back(mk("sh32",      0, 1, 2, 0, 32'h32,   32'h0000BEEF, 32'h0,        32'h0, 32'h00001122, 32'h32));
    tbl.push_back(mk("lw30",      0, 0, 0, 1, 32'h30,   32'h0,        32'h0,        32'h0, 32'hBEEF3344, 32'hBEEF3344));
    tbl.push_back(mk("lh32",      0, 0, 2, 1, 32'h32,   32'h0,        32'h0,        32'h0, 32'hFFFFBEEF, 32'hFFFFBEEF));
    tbl.push_back(mk("lhu30",     0, 0, 1, 1, 32'h30,   32'h0,        32'h0,        32'h0, 32'h00003344, 32'h00003344));
    tbl.push_back(mk("lhu33",     0, 0, 1, 1, 32'h33,   32'h0,        32'h0,        32'h0, 32'h0000BEEF, 32'h0000BEEF));
    tbl.push_back(mk("sw40",      0, 1, 0, 0, 32'h40,   32'hAAAAAAAA, 32'h0,        32'h0, 32'h0,        32'h40));
    tbl.push_back(mk("rdw40",     0, 1, 0, 1, 32'h40,   32'h55555555, 32'h0,        32'h0, 32'hAAAAAAAA, 32'hAAAAAAAA));
    tbl.push_back(mk("lw40",      0, 0, 0, 1, 32'h40,   32'h0,        32'h0,        32'h0, 32'h55555555, 32'h55555555));
    tbl.push_back(mk("sb43",      0, 1, 3, 0, 32'h43,   32'h1234565A, 32'h0,        32'h0, 32'h00000055, 32'h43));
    tbl.push_back(mk("lb43",      0, 0, 4, 1, 32'h43,   32'h0,        32'h0,        32'h0, 32'h0000005A, 32'h0000005A));
    tbl.push_back(mk("sh40",      0, 1, 1, 0, 32'h40,   32'h1234ABCD, 32'h0,        32'h0, 32'h00005555, 32'h40));
    tbl.push_back(mk("lw40_m",    0, 0, 0, 1, 32'h40,   32'h0,        32'h0,        32'h0, 32'h5A55ABCD, 32'h5A55ABCD));
    tbl.push_back(mk("op7_40",    0, 0, 7, 1, 32'h40,   32'h0,        32'h0,        32'h0, 32'h5A55ABCD, 32'h5A55ABCD));
    tbl.push_back(mk("lb41",      0, 0, 4, 1, 32'h41,   32'h0,        32'h0,        32'h0, 32'hFFFFFFAB, 32'hFFFFFFAB));
    tbl.push_back(mk("sw04",      0, 1, 0, 0, 32'h4,    32'hCAFEF00D, 32'h0,        32'h0, 32'h0,        32'h4));
    tbl.push_back(mk("wd0",       0, 0, 0, 0, 32'h7,    32'h0,        32'h3000,     32'h9, 32'hCAFEF00D, 32'h7));
    tbl.push_back(mk("wd1",       0, 0, 0, 1, 32'h7,    32'h0,        32'h3000,     32'h9, 32'hCAFEF00D, 32'hCAFEF00D));
    tbl.push_back(mk("wd2",       0, 0, 0, 2, 32'h7,    32'h0,        32'h3000,     32'h9, 32'hCAFEF00D, 32'h3008));
    tbl.push_back(mk("wd3",       0, 0, 0, 3, 32'h7,    32'h0,        32'h3000,     32'h9, 32'hCAFEF00D, 32'h9));
    tbl.push_back(mk("wd2_wrap",  0, 0, 0, 2, 32'h7,    32'h0,        32'hFFFFFFFC, 32'h9, 32'hCAFEF00D, 32'h4));
    tbl.push_back(mk("sw_oor",    0, 1, 0, 0, 32'h3000, 32'hDEADBEEF, 32'h0,        32'h0, 32'h0,        32'h3000));
    tbl.push_back(mk("lw_oor",    0, 0, 0, 1, 32'h3000, 32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("lw0_oor",   0, 0, 0, 1, 32'h0,    32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("sw_hi",     0, 1, 0, 0, 32'h4010, 32'hDEADBEEF, 32'h0,        32'h0, 32'h0,        32'h4010));
    tbl.push_back(mk("lw10_hi",   0, 0, 0, 1, 32'h10,   32'h0,        32'h0,        32'h0, 32'h0,        32'h0));
    tbl.push_back(mk("sw_last",   0, 1, 0, 0, 32'h2FFC, 32'h13572468, 32'h0,        32'h0, 32'h0,        32'h2FFC));
    tbl.push_back(mk("lw_last",   0, 0, 0, 1, 32'h2FFC, 32'h0,        32'h0,        32'h0, 32'h13572468, 32'h13572468));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check({tbl[i].nm, ".rd"}, MEM_RD, tbl[i].erd);
      check({tbl[i].nm, ".wd"}, MEM_WD, tbl[i].ewd);
      @(posedge clk);
      commit(tbl[i]);
    end

    // Random traffic concentrated on a few low words and the top-of-RAM boundary.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      v.alu = $urandom_range(0, 63);
      else if (r < 8) v.alu = 32'h2FF0 + $urandom_range(0, 31);
      else            v.alu = $urandom;
      v.nm  = "rand";
      v.rst = ($urandom_range(0, 63) == 0);
      v.we  = $urandom_range(0, 1);
      v.op  = 3'($urandom_range(0, 7));
      v.sel = 2'($urandom_range(0, 3));
      v.rt  = $urandom;
      v.pc  = $urandom;
      v.md  = $urandom;
      erd   = mread(v.alu, v.op);
      @(negedge clk);
      drive(v);
      #1;
      check($sformatf("rand%0d.rd a=%h op=%0d", n, v.alu, v.op), MEM_RD, erd);
      check($sformatf("rand%0d.wd sel=%0d", n, v.sel), MEM_WD, mwd(v, erd));
      @(posedge clk);
      commit(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
